// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 datapath widths, NZP condition-code encodings and cc type
package lc3_pkg;
  localparam int LC3_DATA_W = 16;
  localparam int LC3_NUM_REGS = 8;
  typedef logic [2:0] cc_t;
  localparam cc_t CC_N = 3'b100;
  localparam cc_t CC_Z = 3'b010;
  localparam cc_t CC_P = 3'b001;
endpackage

// File: rtl/nzp_gen.sv
// nzp_gen: combinational NZP classifier of a two's-complement word
// Ports: data (DATA_W) in; nzp {N,Z,P} out, exactly one bit set.
module nzp_gen
  import lc3_pkg::*;
#(
  parameter int DATA_W = LC3_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  output cc_t               nzp
);
  assign nzp = data[DATA_W-1] ? CC_N : (data == '0) ? CC_Z : CC_P;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: LC-3 register file with one sync write port, two comb read ports and NZP register
// Ports: clk, rst_n (async active-low); wr_en/wr_addr/wr_data write port;
//        ld_cc loads cc_nzp from wr_data; rd_addr_a/rd_data_a and
//        rd_addr_b/rd_data_b combinational read ports; cc_nzp registered {N,Z,P}.
module reg_file_2r1w
  import lc3_pkg::*;
#(
  parameter int                DATA_W    = LC3_DATA_W,
  parameter int                NUM_REGS  = LC3_NUM_REGS,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ld_cc,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output cc_t               cc_nzp
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  cc_t cc_next;
  logic wr_ok, ok_a, ok_b;
  // Addresses past NUM_REGS exist only when NUM_REGS is not a power of two.
  assign wr_ok = int'(wr_addr) < NUM_REGS;
  assign ok_a = int'(rd_addr_a) < NUM_REGS;
  assign ok_b = int'(rd_addr_b) < NUM_REGS;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_en && wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end
  // Out-of-range reads return 0 even when the address matches a (dropped) write.
  assign rd_data_a = !ok_a ? '0 : (BYPASS && wr_en && rd_addr_a == wr_addr) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = !ok_b ? '0 : (BYPASS && wr_en && rd_addr_b == wr_addr) ? wr_data : regs[rd_addr_b];
  nzp_gen #(.DATA_W(DATA_W)) u_nzp (
    .data(wr_data),
    .nzp (cc_next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cc_nzp <= CC_Z;
    else if (ld_cc) cc_nzp <= cc_next;
  end
endmodule
